// File: rtl/branch_pht_ctrl.sv
// PHT controller: table init sequencing, fetch/update slot arbitration,
// and an update FIFO in front of a 2-bit saturating counter table.
module branch_pht_ctrl #(
    parameter  int ENTRIES    = 64,
    parameter  int PC_W       = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             lookup_v_i,
    input  logic [PC_W-1:0]  lookup_pc_i,
    output logic             lookup_ready_o,
    output logic             pred_v_o,
    output logic             pred_taken_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_v_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    output logic             busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] init_ptr_q;
    logic [1:0]       pht [ENTRIES];

    logic [IDX_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             run, fifo_full, fifo_empty;
    logic             accept, drain, enq, flush;
    logic [IDX_W-1:0] lookup_idx, head_idx;
    logic             head_taken;
    logic [1:0]       head_ctr, next_ctr;
    logic             unused_pc;

    assign lookup_idx = lookup_pc_i[IDX_W+1:2];
    assign unused_pc  = ^{lookup_pc_i[PC_W-1:IDX_W+2], lookup_pc_i[1:0]};

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign {head_idx, head_taken} = fifo_mem[rd_ptr_q];
    assign head_ctr = pht[head_idx];

    // Saturating counter step: taken moves toward 00, not-taken toward 11.
    always_comb begin
        next_ctr = head_ctr;
        if (head_taken) begin
            if (head_ctr != 2'b00) next_ctr = head_ctr - 2'd1;
        end else begin
            if (head_ctr != 2'b11) next_ctr = head_ctr + 2'd1;
        end
    end

    // FSM next state plus slot arbitration and handshake outputs.
    always_comb begin
        state_d        = state_q;
        run            = 1'b0;
        busy_o         = 1'b0;
        lookup_ready_o = 1'b0;
        upd_ready_o    = 1'b0;
        flush          = 1'b0;
        unique case (state_q)
            INIT: begin
                busy_o = 1'b1;
                if (init_ptr_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
            end
            RUN: begin
                run            = 1'b1;
                lookup_ready_o = !fifo_full;
                upd_ready_o    = !fifo_full;
                if (clear_i) begin
                    flush   = 1'b1;
                    state_d = INIT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign accept = lookup_v_i & lookup_ready_o;
    assign drain  = run & !fifo_empty & !accept;
    assign enq    = upd_v_i & upd_ready_o;

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= INIT;
        else            state_q <= state_d;
    end

    // Init pointer walks the table while INIT, restarts on flush.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)         init_ptr_q <= '0;
        else if (state_q == INIT) init_ptr_q <= init_ptr_q + IDX_W'(1);
        else if (flush)         init_ptr_q <= '0;
    end

    // Single table port: init write, or drain read-modify-write.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT)     pht[init_ptr_q] <= 2'b00;
        else if (drain && !flush) pht[head_idx]  <= next_ctr;
    end

    // Update FIFO storage.
    always_ff @(posedge clk_i) begin
        if (enq && !flush) fifo_mem[wr_ptr_q] <= {upd_idx_i, upd_taken_i};
    end

    // FIFO pointers and occupancy; flush drops everything queued.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq)   wr_ptr_q <= wr_ptr_q + PW'(1);
            if (drain) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (enq && !drain)      count_q <= count_q + CW'(1);
            else if (!enq && drain) count_q <= count_q - CW'(1);
        end
    end

    // Prediction register: one-cycle lookup latency, holds when idle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pred_v_o     <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_idx_o   <= '0;
        end else begin
            pred_v_o <= accept;
            if (accept) begin
                pred_taken_o <= ~pht[lookup_idx][1];
                pred_idx_o   <= lookup_idx;
            end
        end
    end

endmodule

// File: tb/tb_branch_pht_ctrl.sv
// Directed bench for branch_pht_ctrl; predictions are checked by a
// queue-driven monitor, control outputs by inline checks.
module tb_branch_pht_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        lookup_v_i = 1'b0;
    logic [31:0] lookup_pc_i = '0;
    logic        lookup_ready_o;
    logic        pred_v_o;
    logic        pred_taken_o;
    logic [5:0]  pred_idx_o;
    logic        upd_v_i = 1'b0;
    logic [5:0]  upd_idx_i = '0;
    logic        upd_taken_i = 1'b0;
    logic        upd_ready_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] exp_q [$];

    branch_pht_ctrl dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .clear_i        (clear_i),
        .lookup_v_i     (lookup_v_i),
        .lookup_pc_i    (lookup_pc_i),
        .lookup_ready_o (lookup_ready_o),
        .pred_v_o       (pred_v_o),
        .pred_taken_o   (pred_taken_o),
        .pred_idx_o     (pred_idx_o),
        .upd_v_i        (upd_v_i),
        .upd_idx_i      (upd_idx_i),
        .upd_taken_i    (upd_taken_i),
        .upd_ready_o    (upd_ready_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every presented prediction must match the queue head.
    always @(negedge clk_i) begin
        if (pred_v_o) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pred_unexpected: got taken=%0b idx=%0d, required none",
                         pred_taken_o, pred_idx_o);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({pred_taken_o, pred_idx_o} !== e) begin
                    n_err++;
                    $display("FAIL pred: got taken=%0b idx=%0d, required taken=%0b idx=%0d",
                             pred_taken_o, pred_idx_o, e[6], e[5:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic t);
        exp_q.push_back({t, pc[7:2]});
    endtask

    task automatic do_lookup(input logic [31:0] pc, input logic t);
        lookup_v_i  = 1'b1;
        lookup_pc_i = pc;
        push_exp(pc, t);
        chk("lookup_ready", int'(lookup_ready_o), 1);
        tick();
        lookup_v_i = 1'b0;
    endtask

    task automatic do_upd(input logic [5:0] idx, input logic t);
        upd_v_i     = 1'b1;
        upd_idx_i   = idx;
        upd_taken_i = t;
        chk("upd_ready", int'(upd_ready_o), 1);
        tick();
        upd_v_i = 1'b0;
        tick();
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        logic rdy_seen = 1'b0;
        while (busy_o && n < 200) begin
            if (lookup_ready_o || upd_ready_o) rdy_seen = 1'b1;
            tick();
            n++;
        end
        chk({nm, "_busy_cycles"}, n, 64);
        chk({nm, "_ready_in_init"}, int'(rdy_seen), 0);
    endtask

    // Lookup plus optional update in one cycle, with control checks.
    task automatic cyc(input logic lv, input logic uv, input logic [5:0] idx,
                       input logic t, input int lr, input int ur);
        lookup_v_i  = lv;
        lookup_pc_i = 32'h28;
        upd_v_i     = uv;
        upd_idx_i   = idx;
        upd_taken_i = t;
        chk("cyc_lookup_ready", int'(lookup_ready_o), lr);
        chk("cyc_upd_ready", int'(upd_ready_o), ur);
        if (lv && lr == 1) push_exp(32'h28, 1'b1);
        tick();
        lookup_v_i = 1'b0;
        upd_v_i    = 1'b0;
    endtask

    initial begin
        // 1: reset values, INIT length, first lookups predict taken
        #2;
        chk("rst_busy", int'(busy_o), 1);
        chk("rst_pred_v", int'(pred_v_o), 0);
        chk("rst_lookup_ready", int'(lookup_ready_o), 0);
        chk("rst_upd_ready", int'(upd_ready_o), 0);
        tick();
        tick();
        reset_n_i = 1'b1;
        wait_init("init1");
        do_lookup(32'h100, 1'b1);
        do_lookup(32'h3C, 1'b1);

        // 2: idx 5 not-taken x3 then saturation check
        do_upd(6'd5, 1'b0);
        do_upd(6'd5, 1'b0);
        do_upd(6'd5, 1'b0);
        do_lookup(32'h14, 1'b0);
        do_upd(6'd5, 1'b0);
        do_lookup(32'h14, 1'b0);
        do_upd(6'd5, 1'b1);
        do_lookup(32'h14, 1'b0);

        // preset idx 7 to 11 and idx 3 to 10
        do_upd(6'd7, 1'b0);
        do_upd(6'd7, 1'b0);
        do_upd(6'd7, 1'b0);
        do_upd(6'd3, 1'b0);
        do_upd(6'd3, 1'b0);

        // 3: continuous lookups fill the FIFO; full forces one drain
        cyc(1, 1, 6'd20, 1, 1, 1);
        cyc(1, 1, 6'd21, 1, 1, 1);
        cyc(1, 1, 6'd22, 1, 1, 1);
        cyc(1, 1, 6'd23, 1, 1, 1);
        cyc(1, 0, 6'd0, 0, 0, 0);
        cyc(1, 0, 6'd0, 0, 1, 1);
        repeat (5) tick();

        // 4: enqueue+drain at count 2 keeps count; order preserved
        cyc(1, 1, 6'd3, 1, 1, 1);
        cyc(1, 1, 6'd3, 0, 1, 1);
        cyc(0, 1, 6'd7, 0, 1, 1);
        cyc(1, 1, 6'd7, 1, 1, 1);
        cyc(1, 1, 6'd9, 1, 1, 1);
        cyc(0, 0, 6'd0, 0, 0, 0);
        repeat (6) tick();
        do_lookup(32'h0C, 1'b0);
        do_lookup(32'h1C, 1'b0);
        do_upd(6'd7, 1'b1);
        do_lookup(32'h1C, 1'b1);

        // 5: clear with 3 queued updates
        cyc(1, 1, 6'd12, 0, 1, 1);
        cyc(1, 1, 6'd12, 0, 1, 1);
        cyc(1, 1, 6'd12, 0, 1, 1);
        clear_i     = 1'b1;
        lookup_v_i  = 1'b1;
        lookup_pc_i = 32'h28;
        push_exp(32'h28, 1'b1);
        tick();
        clear_i    = 1'b0;
        lookup_v_i = 1'b0;
        chk("clr_busy", int'(busy_o), 1);
        chk("clr_upd_ready", int'(upd_ready_o), 0);
        wait_init("init2");
        do_lookup(32'h30, 1'b1);
        do_lookup(32'h14, 1'b1);
        do_lookup(32'h1C, 1'b1);
        do_lookup(32'h0C, 1'b1);

        // 6: reset mid-drain
        lookup_v_i  = 1'b1;
        lookup_pc_i = 32'h14;
        upd_v_i     = 1'b1;
        upd_idx_i   = 6'd30;
        upd_taken_i = 1'b0;
        push_exp(32'h14, 1'b1);
        tick();
        lookup_v_i = 1'b0;
        tick();
        upd_v_i = 1'b0;
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_o), 1);
        chk("mid_rst_pred_v", int'(pred_v_o), 0);
        chk("mid_rst_pred_taken", int'(pred_taken_o), 0);
        chk("mid_rst_pred_idx", int'(pred_idx_o), 0);
        chk("mid_rst_lookup_ready", int'(lookup_ready_o), 0);
        chk("mid_rst_upd_ready", int'(upd_ready_o), 0);
        tick();
        tick();
        reset_n_i = 1'b1;
        wait_init("init3");
        do_lookup(32'h78, 1'b1);
        do_lookup(32'h14, 1'b1);

        repeat (3) tick();
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
